addsub_rr_scheduler: RTL and testbench

//  Shares one 8-bit signed add/sub accumulator among NUM_REQ requesters via round-robin arbitration.

---
 rtl/addsub_rr_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_addsub_rr_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_rr_scheduler.sv
// addsub_rr_scheduler: NUM_REQ requesters share one signed add/sub accumulator via round-robin grant.
// Optional macro ADDSUB_OVF_EN adds result_ovf_o, a sticky per-job signed overflow flag.
module addsub_rr_scheduler #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ID_W    = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ-1:0]       req_mode_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_c_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_d_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     busy_o,
    output logic [WIDTH-1:0]         result_o,
    output logic                     result_valid_o,
`ifdef ADDSUB_OVF_EN
    output logic                     result_ovf_o,
`endif
    output logic [ID_W-1:0]          result_id_o
);

    localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] GRANT_ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, STEP_B, STEP_C, STEP_D} state_e;

    state_e               state_q;
    logic [ID_W-1:0]      last_q;
    logic [ID_W-1:0]      id_q;
    logic                 mode_q;
    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     c_q;
    logic [WIDTH-1:0]     d_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic                 busy_q;
    logic [WIDTH-1:0]     result_q;
    logic                 result_valid_q;
    logic [ID_W-1:0]      result_id_q;

    logic                 found;
    int unsigned          cand;
    logic [ID_W-1:0]      winner_d;
    logic                 win_mode;
    logic [WIDTH-1:0]     win_a;
    logic [WIDTH-1:0]     win_b;
    logic [WIDTH-1:0]     win_c;
    logic [WIDTH-1:0]     win_d;

    logic [WIDTH-1:0]     op;
    logic                 sub;
    logic [WIDTH-1:0]     sum;

    // Round-robin pick: first active request after the previous winner, with its operands.
    always_comb begin
        found    = 1'b0;
        cand     = 0;
        winner_d = '0;
        win_mode = 1'b0;
        win_a    = '0;
        win_b    = '0;
        win_c    = '0;
        win_d    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last_q) + k) % NUM_REQ;
            if (!found && req_i[SEL_W'(cand)]) begin
                found    = 1'b1;
                winner_d = ID_W'(cand);
                win_mode = req_mode_i[SEL_W'(cand)];
                win_a    = WIDTH'(req_a_i >> (cand * WIDTH));
                win_b    = WIDTH'(req_b_i >> (cand * WIDTH));
                win_c    = WIDTH'(req_c_i >> (cand * WIDTH));
                win_d    = WIDTH'(req_d_i >> (cand * WIDTH));
            end
        end
    end

    // Shared accumulator step; B is subtracted in mode 1, D in mode 0.
    always_comb begin
        op  = b_q;
        sub = mode_q;
        case (state_q)
            STEP_C: begin
                op  = c_q;
                sub = 1'b0;
            end
            STEP_D: begin
                op  = d_q;
                sub = !mode_q;
            end
            default: begin
            end
        endcase
        sum = sub ? (acc_q - op) : (acc_q + op);
    end

`ifdef ADDSUB_OVF_EN
    logic ovf_q;
    logic result_ovf_q;
    logic step_ovf;

    // Signed overflow: result sign differs from acc when the effective operand signs agree.
    always_comb begin
        if (sub) begin
            step_ovf = (acc_q[WIDTH-1] != op[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
        end else begin
            step_ovf = (acc_q[WIDTH-1] == op[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q        <= 1'b0;
            result_ovf_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE:           if (found) ovf_q <= 1'b0;
                STEP_B, STEP_C: ovf_q <= ovf_q | step_ovf;
                STEP_D:         result_ovf_q <= ovf_q | step_ovf;
                default:        ovf_q <= ovf_q;
            endcase
        end
    end

    assign result_ovf_o = result_ovf_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            last_q         <= ID_W'(NUM_REQ - 1);
            id_q           <= '0;
            mode_q         <= 1'b0;
            acc_q          <= '0;
            b_q            <= '0;
            c_q            <= '0;
            d_q            <= '0;
            grant_q        <= '0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            result_id_q    <= '0;
        end else begin
            grant_q        <= '0;
            result_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q <= GRANT_ONE << winner_d;
                        last_q  <= winner_d;
                        id_q    <= winner_d;
                        mode_q  <= win_mode;
                        acc_q   <= win_a;
                        b_q     <= win_b;
                        c_q     <= win_c;
                        d_q     <= win_d;
                        busy_q  <= 1'b1;
                        state_q <= STEP_B;
                    end
                end
                STEP_B: begin
                    acc_q   <= sum;
                    state_q <= STEP_C;
                end
                STEP_C: begin
                    acc_q   <= sum;
                    state_q <= STEP_D;
                end
                STEP_D: begin
                    result_q       <= sum;
                    result_valid_q <= 1'b1;
                    result_id_q    <= id_q;
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o        = grant_q;
    assign busy_o         = busy_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign result_id_o    = result_id_q;

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Bench for addsub_rr_scheduler: directed scenarios plus random traffic against a job-level model.
module tb_addsub_rr_scheduler;

    localparam int NUM_REQ = 2;
    localparam int W       = 8;
    localparam int ID_W    = 1;
    localparam int OPW     = NUM_REQ * W;
    localparam int SMAX    = (1 << (W - 1)) - 1;
    localparam int SMIN    = -(1 << (W - 1));

    logic               clk = 1'b0;
    logic               rst_ni;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] mode;
    logic [OPW-1:0]     a_in, b_in, c_in, d_in;
    logic [NUM_REQ-1:0] grant_o;
    logic               busy_o;
    logic [W-1:0]       result_o;
    logic               result_valid_o;
    logic [ID_W-1:0]    result_id_o;
`ifdef ADDSUB_OVF_EN
    logic               result_ovf_o;
`endif

    addsub_rr_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(W), .ID_W(ID_W)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .req_i          (req),
        .req_mode_i     (mode),
        .req_a_i        (a_in),
        .req_b_i        (b_in),
        .req_c_i        (c_in),
        .req_d_i        (d_in),
        .grant_o        (grant_o),
        .busy_o         (busy_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
`ifdef ADDSUB_OVF_EN
        .result_ovf_o   (result_ovf_o),
`endif
        .result_id_o    (result_id_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Job-level reference: cycles left in the current job, the RR pointer and the pending answer.
    int                 m_cnt;
    int                 m_last;
    logic [W-1:0]       m_res_pend, m_res;
    int                 m_id_pend, m_id;
    bit                 m_ovf_pend, m_ovf;
    logic [NUM_REQ-1:0] last_grant;
    bit                 last_rv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    function automatic int wrap(input int v);
        logic [W-1:0] t;
        t = v[W-1:0];
        return int'($signed(t));
    endfunction

    function automatic bit out_of_range(input int v);
        return (v > SMAX) || (v < SMIN);
    endfunction

    // Whole-job arithmetic on plain integers, wrapping after each step.
    function automatic void job_eval(input int i, output logic [W-1:0] r, output bit ovf);
        int av, bv, cv, dv, x;
        bit m;
        av  = int'($signed(a_in[i*W +: W]));
        bv  = int'($signed(b_in[i*W +: W]));
        cv  = int'($signed(c_in[i*W +: W]));
        dv  = int'($signed(d_in[i*W +: W]));
        m   = mode[i];
        x   = m ? av - bv : av + bv;
        ovf = out_of_range(x);
        x   = wrap(x) + cv;
        ovf = ovf | out_of_range(x);
        x   = m ? wrap(x) + dv : wrap(x) - dv;
        ovf = ovf | out_of_range(x);
        r   = W'(x);
    endfunction

    task automatic reset_model();
        m_cnt      = 0;
        m_last     = NUM_REQ - 1;
        m_res      = '0;
        m_id       = 0;
        m_ovf      = 1'b0;
        last_grant = '0;
        last_rv    = 1'b0;
    endtask

    task automatic set_op(input int i, input bit m, input int av, input int bv, input int cv, input int dv);
        mode[i]       = m;
        a_in[i*W +: W] = W'(av);
        b_in[i*W +: W] = W'(bv);
        c_in[i*W +: W] = W'(cv);
        d_in[i*W +: W] = W'(dv);
    endtask

    // Predict one clock edge from the current inputs, advance, then compare.
    task automatic tick();
        logic [NUM_REQ-1:0] eg;
        bit erv;
        bit found;
        int idx;
        eg    = '0;
        erv   = 1'b0;
        found = 1'b0;
        if (m_cnt == 0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (m_last + k) % NUM_REQ;
                if (!found && req[idx]) begin
                    found = 1'b1;
                    eg[idx] = 1'b1;
                    m_last = idx;
                    m_id_pend = idx;
                    job_eval(idx, m_res_pend, m_ovf_pend);
                    m_cnt = 3;
                end
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) begin
                erv   = 1'b1;
                m_res = m_res_pend;
                m_id  = m_id_pend;
                m_ovf = m_ovf_pend;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("grant", 32'(grant_o), 32'(eg));
        check("result_valid", 32'(result_valid_o), 32'(erv));
        check("busy", 32'(busy_o), 32'(m_cnt != 0));
        check("result", 32'(result_o), 32'(m_res));
        check("result_id", 32'(result_id_o), 32'(m_id));
`ifdef ADDSUB_OVF_EN
        if (erv) check("result_ovf", 32'(result_ovf_o), 32'(m_ovf));
`endif
        last_grant = eg;
        last_rv    = erv;
    endtask

    function automatic logic [W-1:0] rand_byte();
        case ($urandom_range(0, 5))
            0:       return W'(SMAX);
            1:       return W'(SMIN);
            2:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    logic [NUM_REQ-1:0] g4 [12];
    logic               rv4 [12];

    initial begin
        rst_ni = 1'b0;
        req    = '0;
        mode   = '0;
        a_in   = '0;
        b_in   = '0;
        c_in   = '0;
        d_in   = '0;
        reset_model();
        #1;
        check("rst_grant", 32'(grant_o), 32'(0));
        check("rst_busy", 32'(busy_o), 32'(0));
        check("rst_result", 32'(result_o), 32'(0));
        check("rst_valid", 32'(result_valid_o), 32'(0));
        check("rst_id", 32'(result_id_o), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;

        // T1
        set_op(0, 1'b0, 1, 2, -1, 2);
        req = 2'b01;
        tick();
        check("t1_grant", 32'(grant_o), 32'(2'b01));
        req = '0;
        repeat (3) tick();
        check("t1_valid", 32'(result_valid_o), 32'(1));
        check("t1_result", 32'(result_o), 32'(8'd0));
        check("t1_id", 32'(result_id_o), 32'(0));

        // T2
        set_op(1, 1'b1, -2, 1, 1, 4);
        req = 2'b10;
        tick();
        check("t2_grant", 32'(grant_o), 32'(2'b10));
        req = '0;
        repeat (3) tick();
        check("t2_result", 32'(result_o), 32'(8'd2));
        check("t2_id", 32'(result_id_o), 32'(1));

        // T3: simultaneous requests
        set_op(0, 1'b0, 1, -1, -1, 2);
        set_op(1, 1'b0, 1, -1, -1, 2);
        req = 2'b11;
        tick();
        check("t3_grant0", 32'(grant_o), 32'(2'b01));
        req = 2'b10;
        repeat (3) tick();
        check("t3_result0", 32'(result_o), 32'(8'hFD));
        check("t3_id0", 32'(result_id_o), 32'(0));
        tick();
        check("t3_grant1", 32'(grant_o), 32'(2'b10));
        req = '0;
        repeat (3) tick();
        check("t3_result1", 32'(result_o), 32'(8'hFD));
        check("t3_id1", 32'(result_id_o), 32'(1));

        // T4: both held high for three jobs
        req = 2'b11;
        for (int t = 0; t < 12; t++) begin
            if (t == 9) req = '0;
            tick();
            g4[t]  = grant_o;
            rv4[t] = result_valid_o;
        end
        check("t4_g0", 32'(g4[0]), 32'(2'b01));
        check("t4_g1", 32'(g4[4]), 32'(2'b10));
        check("t4_g2", 32'(g4[8]), 32'(2'b01));
        check("t4_rv_then_grant", 32'(rv4[3]), 32'(1));

        // T5: reset during STEP_C discards the job and restores the RR pointer
        set_op(0, 1'b1, -2, 2, -1, 2);
        req = 2'b01;
        tick();
        check("t5_grant", 32'(grant_o), 32'(2'b01));
        req = '0;
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        reset_model();
        check("t5_busy", 32'(busy_o), 32'(0));
        check("t5_result", 32'(result_o), 32'(0));
        check("t5_valid", 32'(result_valid_o), 32'(0));
        check("t5_id", 32'(result_id_o), 32'(0));
        @(posedge clk);
        #1;
        check("t5_valid_in_rst", 32'(result_valid_o), 32'(0));
        @(negedge clk);
        rst_ni = 1'b1;
        set_op(0, 1'b0, 5, 5, 5, 5);
        set_op(1, 1'b1, 7, 7, 7, 7);
        req = 2'b11;
        tick();
        check("t5_next_grant", 32'(grant_o), 32'(2'b01));
        req = '0;
        repeat (4) tick();

`ifdef ADDSUB_OVF_EN
        // T6
        set_op(0, 1'b0, 127, 1, 0, 0);
        req = 2'b01;
        tick();
        req = '0;
        repeat (3) tick();
        check("t6_result", 32'(result_o), 32'(8'h80));
        check("t6_ovf", 32'(result_ovf_o), 32'(1));
        set_op(0, 1'b0, 1, 2, -1, 2);
        req = 2'b01;
        tick();
        req = '0;
        repeat (3) tick();
        check("t6_result2", 32'(result_o), 32'(8'd0));
        check("t6_ovf2", 32'(result_ovf_o), 32'(0));
`endif

        // Random traffic: operands and modes churn every cycle; only the grant edge matters.
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (last_grant[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 2) == 0) req[i] = 1'b1;
            end
            if ($urandom_range(0, 1) == 1) begin
                mode = NUM_REQ'($urandom);
                for (int i = 0; i < NUM_REQ; i++) begin
                    a_in[i*W +: W] = rand_byte();
                    b_in[i*W +: W] = rand_byte();
                    c_in[i*W +: W] = rand_byte();
                    d_in[i*W +: W] = rand_byte();
                end
            end
            tick();
        end
        req = '0;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
